// File: rtl/button_event_reader_pkg.sv
// Shared types and register map for the button event reader.
// Contents: FSM state enum and button PIO register addresses.
package button_event_reader_pkg;

    typedef enum logic [2:0] {
        INIT_MASK,
        INIT_CLR,
        IDLE,
        RD_CMD,
        RD_WAIT,
        CLR
    } state_t;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/button_poll_timer.sv
// Poll interval counter: counts while enabled, held at 0 otherwise.
// Ports: clk, reset_n, enable, clear (restart), expired (pulse at POLL_CYCLES-1).
module button_poll_timer #(
    parameter int POLL_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || clear || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/button_event_reader.sv
// Avalon-MM initiator that polls the button PIO edge_capture register
// and emits captured edges on a valid/ready stream.
// Ports: clk, reset_n, enable; avm_* bus to the PIO; irq_in;
// evt_valid/evt_ready/evt_data stream; evt_overrun pulse.
module button_event_reader
    import button_event_reader_pkg::*;
#(
    parameter int          WIDTH        = 4,
    parameter int          POLL_CYCLES  = 50000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] IRQ_MASK     = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             irq_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_overrun
);

    localparam int LW = (READ_LATENCY > 1) ?
                        $clog2(READ_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

    state_t           state;
    logic [LW-1:0]    lat;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] sample;
    logic             sample_now;
    logic             merge;
    logic             accept;
    logic             expired;
    logic             go;
    logic             unused_readdata;

    assign unused_readdata = ^avm_readdata[31:WIDTH];

    assign sample     = avm_readdata[WIDTH-1:0];
    assign sample_now = (state == RD_WAIT) && (lat == LAT_LAST);
    assign merge      = sample_now && (sample != '0);
    assign accept     = evt_valid && evt_ready;

    // irq only shortcuts the timer when the PIO was told to raise it
    assign go = (state == IDLE) && enable &&
                (expired || ((IRQ_MASK != 32'h0) && irq_in));

    button_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable && (state == IDLE)),
        .clear  (go),
        .expired(expired)
    );

    // Bus outputs are registered one cycle ahead: the access is
    // presented during the state entered on this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT_MASK;
            lat            <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= PIO_ADDR_DATA;
            avm_writedata  <= 32'h0;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= PIO_ADDR_DATA;
            avm_writedata  <= 32'h0;
            unique case (state)
                INIT_MASK: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= PIO_ADDR_MASK;
                    avm_writedata  <= IRQ_MASK;
                    state          <= INIT_CLR;
                end
                INIT_CLR: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= PIO_ADDR_EDGE;
                    state          <= IDLE;
                end
                IDLE: begin
                    if (go) begin
                        avm_chipselect <= 1'b1;
                        avm_address    <= PIO_ADDR_EDGE;
                        state          <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    lat   <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (sample_now) begin
                        if (sample != '0) begin
                            avm_chipselect <= 1'b1;
                            avm_write_n    <= 1'b0;
                            avm_address    <= PIO_ADDR_EDGE;
                            state          <= CLR;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                CLR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT_MASK;
                end
            endcase
        end
    end

    // Output register plus one pending accumulator; a pending word is
    // promoted on handshake while a fresh sample refills pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            pending     <= '0;
            evt_overrun <= 1'b0;
        end else begin
            evt_overrun <= 1'b0;
            if (accept) begin
                if (pending != '0) begin
                    evt_data  <= pending;
                    evt_valid <= 1'b1;
                    pending   <= merge ? sample : '0;
                end else if (merge) begin
                    evt_data  <= sample;
                    evt_valid <= 1'b1;
                end else begin
                    evt_valid <= 1'b0;
                end
            end else if (merge) begin
                if (!evt_valid) begin
                    evt_data  <= sample;
                    evt_valid <= 1'b1;
                end else begin
                    pending     <= pending | sample;
                    evt_overrun <= (pending != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_reader.sv
// Self-checking bench for button_event_reader with a behavioural
// button PIO responder (falling-edge capture, write-to-clear).
module tb_button_event_reader;

    localparam int POLL = 16;
    localparam int LAT  = 1;

    typedef struct {
        logic [3:0] bits;
        logic [3:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  address [2];
    logic        chipselect [2];
    logic        write_n [2];
    logic [31:0] writedata [2];
    logic [31:0] readdata [2];
    logic        irq [2];
    logic        evt_valid [2];
    logic        evt_ready [2];
    logic [3:0]  evt_data [2];
    logic        evt_overrun [2];
    logic [3:0]  in_port [2];
    logic [3:0]  in_d [2];
    logic [3:0]  edge_cap [2];
    logic [3:0]  mask [2];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ov_cnt = 0;
    int valid_cyc = 0;

    always #5 clk = ~clk;

    button_event_reader #(
        .WIDTH(4), .POLL_CYCLES(POLL),
        .READ_LATENCY(LAT), .IRQ_MASK(32'h0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(address[0]),
        .avm_chipselect(chipselect[0]),
        .avm_write_n(write_n[0]),
        .avm_writedata(writedata[0]),
        .avm_readdata(readdata[0]),
        .irq_in(irq[0]),
        .evt_valid(evt_valid[0]),
        .evt_ready(evt_ready[0]),
        .evt_data(evt_data[0]),
        .evt_overrun(evt_overrun[0])
    );

    button_event_reader #(
        .WIDTH(4), .POLL_CYCLES(POLL),
        .READ_LATENCY(LAT), .IRQ_MASK(32'hF)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(address[1]),
        .avm_chipselect(chipselect[1]),
        .avm_write_n(write_n[1]),
        .avm_writedata(writedata[1]),
        .avm_readdata(readdata[1]),
        .irq_in(irq[1]),
        .evt_valid(evt_valid[1]),
        .evt_ready(evt_ready[1]),
        .evt_data(evt_data[1]),
        .evt_overrun(evt_overrun[1])
    );

    // PIO responder model for both instances
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 2; g++) begin
                mask[g]     <= 4'h0;
                edge_cap[g] <= 4'h0;
                readdata[g] <= 32'h0;
                in_d[g]     <= 4'hF;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                in_d[g]     <= in_port[g];
                readdata[g] <= 32'h0;
                if (chipselect[g] && write_n[g]) begin
                    case (address[g])
                        2'd0: readdata[g] <= {28'h0, in_port[g]};
                        2'd2: readdata[g] <= {28'h0, mask[g]};
                        2'd3: readdata[g] <= {28'h0, edge_cap[g]};
                        default: readdata[g] <= 32'h0;
                    endcase
                end
                if (chipselect[g] && !write_n[g] && address[g] == 2'd2)
                    mask[g] <= writedata[g][3:0];
                if (chipselect[g] && !write_n[g] && address[g] == 2'd3)
                    edge_cap[g] <= 4'h0;
                else
                    edge_cap[g] <= edge_cap[g] | (in_d[g] & ~in_port[g]);
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) irq[g] = |(edge_cap[g] & mask[g]);
    end

    // Bus activity counters for instance 0
    always @(posedge clk) begin
        if (reset_n) begin
            if (chipselect[0] && !write_n[0]) wr_cnt++;
            if (chipselect[0] && write_n[0]) rd_cnt++;
            if (evt_overrun[0]) ov_cnt++;
            if (evt_valid[0]) valid_cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic inject(input int g, input logic [3:0] bits);
        @(negedge clk);
        in_port[g] = ~bits;
        @(negedge clk);
        in_port[g] = 4'hF;
    endtask

    task automatic wait_valid(input int g, input int maxc,
                              output bit ok, output logic [3:0] d);
        ok = 1'b0;
        d  = 4'h0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (evt_valid[g]) begin
                ok = 1'b1;
                d  = evt_data[g];
            end
        end
    endtask

    task automatic wait_wr(input int maxc, output bit ok);
        int start;
        start = wr_cnt;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (wr_cnt != start) ok = 1'b1;
        end
    endtask

    task automatic wait_read(input int g, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (chipselect[g] && write_n[g]) ok = 1'b1;
        end
    endtask

    task automatic check_init();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("init_mask_cs", 32'(chipselect[g]), 32'd1);
            check("init_mask_wn", 32'(write_n[g]), 32'd0);
            check("init_mask_addr", 32'(address[g]), 32'd2);
            check("init_mask_wd", writedata[g],
                  (g == 1) ? 32'hF : 32'h0);
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("init_clr_cs", 32'(chipselect[g]), 32'd1);
            check("init_clr_wn", 32'(write_n[g]), 32'd0);
            check("init_clr_addr", 32'(address[g]), 32'd3);
            check("init_clr_wd", writedata[g], 32'h0);
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("init_idle_cs", 32'(chipselect[g]), 32'd0);
            check("init_valid", 32'(evt_valid[g]), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs [5];
        bit         ok;
        logic [3:0] d;
        int         w0, r0, v0, o0;

        vecs[0] = '{4'b0100, 4'b0100};
        vecs[1] = '{4'b0001, 4'b0001};
        vecs[2] = '{4'b1010, 4'b1010};
        vecs[3] = '{4'b1111, 4'b1111};
        vecs[4] = '{4'b1000, 4'b1000};

        reset_n      = 1'b0;
        enable       = 1'b1;
        in_port[0]   = 4'hF;
        in_port[1]   = 4'hF;
        evt_ready[0] = 1'b1;
        evt_ready[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_cs", 32'(chipselect[g]), 32'd0);
            check("rst_wn", 32'(write_n[g]), 32'd1);
            check("rst_addr", 32'(address[g]), 32'd0);
            check("rst_wd", writedata[g], 32'h0);
            check("rst_valid", 32'(evt_valid[g]), 32'd0);
            check("rst_data", 32'(evt_data[g]), 32'd0);
            check("rst_ovr", 32'(evt_overrun[g]), 32'd0);
        end
        reset_n = 1'b1;
        check_init();

        // single edge events, consumer always ready
        for (int i = 0; i < 5; i++) begin
            inject(0, vecs[i].bits);
            wait_valid(0, POLL + LAT + 3, ok, d);
            check("evt_seen", 32'(ok), 32'd1);
            check("evt_data", 32'(d), 32'(vecs[i].exp_data));
            repeat (3) @(negedge clk);
            check("edge_cleared", 32'(edge_cap[0]), 32'd0);
            check("evt_dropped", 32'(evt_valid[0]), 32'd0);
        end

        // quiet period: reads only
        w0 = wr_cnt;
        r0 = rd_cnt;
        v0 = valid_cyc;
        repeat (100) @(negedge clk);
        check("quiet_writes", 32'(wr_cnt - w0), 32'd0);
        check("quiet_reads", 32'((rd_cnt - r0 >= 5) &&
                                 (rd_cnt - r0 <= 6)), 32'd1);
        check("quiet_valid", 32'(valid_cyc - v0), 32'd0);

        // disabled: no polling at all
        enable = 1'b0;
        repeat (5) @(negedge clk);
        r0 = rd_cnt;
        repeat (40) @(negedge clk);
        check("disabled_reads", 32'(rd_cnt - r0), 32'd0);
        enable = 1'b1;

        // back-pressure with pending accumulation and overrun
        evt_ready[0] = 1'b0;
        o0 = ov_cnt;
        inject(0, 4'b0001);
        wait_valid(0, POLL + LAT + 3, ok, d);
        check("bp_first_seen", 32'(ok), 32'd1);
        check("bp_first_data", 32'(d), 32'h1);
        repeat (3) @(negedge clk);
        inject(0, 4'b0010);
        wait_wr(30, ok);
        check("bp_second_clr", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_no_ovr", 32'(ov_cnt - o0), 32'd0);
        check("bp_hold_data", 32'(evt_data[0]), 32'h1);
        inject(0, 4'b0010);
        wait_wr(30, ok);
        check("bp_third_clr", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_ovr_once", 32'(ov_cnt - o0), 32'd1);
        check("bp_hold_valid", 32'(evt_valid[0]), 32'd1);
        check("bp_hold_data2", 32'(evt_data[0]), 32'h1);
        evt_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_pend_valid", 32'(evt_valid[0]), 32'd1);
        check("bp_pend_data", 32'(evt_data[0]), 32'h2);
        @(negedge clk);
        check("bp_drain", 32'(evt_valid[0]), 32'd0);

        // irq-triggered poll on the masked instance
        wait_read(1, 30, ok);
        check("irq_sync_read", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        inject(1, 4'b1000);
        check("irq_high", 32'(irq[1]), 32'd1);
        check("irq_no_early", 32'(chipselect[1]), 32'd0);
        @(negedge clk);
        check("irq_rd_cs", 32'(chipselect[1]), 32'd1);
        check("irq_rd_wn", 32'(write_n[1]), 32'd1);
        check("irq_rd_addr", 32'(address[1]), 32'd3);
        wait_valid(1, 10, ok, d);
        check("irq_evt_seen", 32'(ok), 32'd1);
        check("irq_evt_data", 32'(d), 32'h8);
        repeat (3) @(negedge clk);
        check("irq_cleared", 32'(irq[1]), 32'd0);

        // reset in RD_WAIT with an event held
        evt_ready[0] = 1'b0;
        inject(0, 4'b0100);
        wait_valid(0, POLL + LAT + 3, ok, d);
        check("mr_evt_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        wait_read(0, 30, ok);
        check("mr_read_seen", 32'(ok), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mr_cs", 32'(chipselect[0]), 32'd0);
        check("mr_wn", 32'(write_n[0]), 32'd1);
        check("mr_addr", 32'(address[0]), 32'd0);
        check("mr_valid", 32'(evt_valid[0]), 32'd0);
        check("mr_data", 32'(evt_data[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        evt_ready[0] = 1'b1;
        check_init();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
